// File: rtl/blink_mon_pkg.sv
// Shared types and defaults for the blinker period monitor.
package blink_mon_pkg;

  localparam int DEFAULT_PERIOD = 512;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_LATE  = 2'd1,
    FC_EARLY = 2'd2,
    FC_NOTOG = 2'd3
  } fcode_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/blink_mon_timer.sv
// Saturating flg-to-flg interval counter; reads 1 in the cycle after a restart.
module blink_mon_timer
  import blink_mon_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD,
  parameter int CW     = $clog2(PERIOD) + 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic clear,
  output logic ivl_eq,
  output logic ivl_lt
);

  localparam logic [CW-1:0] PER_C = CW'(PERIOD);
  localparam logic [CW-1:0] SAT_C = CW'(PERIOD + 1);

  logic [CW-1:0] ivl_q, ivl_d;

  // clear (fault acknowledge) outranks a coincident restart
  always_comb begin
    ivl_d = ivl_q;
    if (clear)             ivl_d = '0;
    else if (restart)      ivl_d = CW'(1);
    else if (ivl_q < SAT_C) ivl_d = ivl_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ivl_q <= '0;
    else     ivl_q <= ivl_d;
  end

  assign ivl_eq = (ivl_q == PER_C);
  assign ivl_lt = (ivl_q <  PER_C);

endmodule

// File: rtl/blink_mon.sv
// Blinker period/toggle monitor: SYNC -> RUN -> FAULT with latched fault code.
// Define BLINK_MON_EARLY_CHECK_EN to fault on flg pulses arriving before PERIOD.
module blink_mon
  import blink_mon_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD,
  parameter int CW     = $clog2(PERIOD) + 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flg,
  input  logic       led,
  input  logic       clr,
  output logic       alive,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] pulse_cnt
);

`ifdef BLINK_MON_EARLY_CHECK_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  state_e     state_q, state_d;
  fcode_e     code_q, code_d, fc;
  logic [7:0] cnt_q, cnt_d;
  logic       chk_q, chk_d;
  logic       cap_q, cap_d;
  logic       alive_q, alive_d;
  logic       fault_q, fault_d;
  logic       ivl_eq, ivl_lt, ivl_clear;

  assign ivl_clear = (state_q == ST_FAULT) && clr;

  blink_mon_timer #(.PERIOD(PERIOD), .CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(flg),
    .clear  (ivl_clear),
    .ivl_eq (ivl_eq),
    .ivl_lt (ivl_lt)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    cap_d   = cap_q;
    fc      = FC_NONE;
    unique case (state_q)
      ST_SYNC: begin
        if (clr) cnt_d = '0;
        if (flg) begin
          state_d = ST_RUN;
          cnt_d   = sat_inc8(cnt_d);
          chk_d   = 1'b1;
          cap_d   = led;
        end
      end
      ST_RUN: begin
        // a pending toggle check is consumed in the cycle right after a pulse
        chk_d = 1'b0;
        if (chk_q && (led == cap_q))         fc = FC_NOTOG;
        else if (EARLY_EN && flg && ivl_lt) fc = FC_EARLY;
        else if (!flg && ivl_eq)            fc = FC_LATE;
        if (fc != FC_NONE) begin
          state_d = ST_FAULT;
          code_d  = fc;
        end else begin
          if (clr) cnt_d = '0;
          if (flg) begin
            cnt_d = sat_inc8(cnt_d);
            chk_d = 1'b1;
            cap_d = led;
          end
        end
      end
      ST_FAULT: begin
        if (clr) begin
          state_d = ST_SYNC;
          code_d  = FC_NONE;
          cnt_d   = '0;
          chk_d   = 1'b0;
        end
      end
      default: state_d = ST_SYNC;
    endcase
    alive_d = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SYNC;
      code_q  <= FC_NONE;
      cnt_q   <= '0;
      chk_q   <= 1'b0;
      cap_q   <= 1'b0;
      alive_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      cap_q   <= cap_d;
      alive_q <= alive_d;
      fault_q <= fault_d;
    end
  end

  assign alive      = alive_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign pulse_cnt  = cnt_q;

endmodule
